// File: rtl/background_fill_controller.sv
// Background fill controller.
// Walks the tile address space once per frame. Each address goes to the background generator,
// and the returned colour is streamed to the framebuffer over a valid/ready handshake.
// The background-set selection is latched only at frame start, so a frame never mixes sets.
module background_fill_controller #(
    parameter int unsigned H_TILES = 120,
    parameter int unsigned V_TILES = 68,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned FCNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [1:0]        i_bg_req,
    input  logic              i_bg_req_valid,
    output logic [1:0]        o_bg_set,
    output logic [ADDR_W-1:0] o_gen_address,
    input  logic [DATA_W-1:0] i_gen_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_address,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [FCNT_W-1:0] o_frame_count
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_TILES * V_TILES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream,
        StDone
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          pending_q;
    logic [1:0]          bg_set_q;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [FCNT_W-1:0]   frame_count_q;
    logic                load_set;
    logic                fire;

    // A write is accepted only while streaming and the framebuffer is ready
    assign fire = (state_q == StStream) && i_wr_ready;

    // State, address and frame-counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            wr_addr_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            if (state_q == StDone) begin
                frame_count_q <= frame_count_q + FCNT_W'(1);
            end
        end
    end

    // Pending set tracks the most recent request; the active set is frozen for the whole frame
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= 2'b00;
            bg_set_q  <= 2'b00;
        end else begin
            if (i_bg_req_valid) begin
                pending_q <= i_bg_req;
            end
            // A request arriving with the start pulse wins over the older pending value
            if (load_set) begin
                bg_set_q <= i_bg_req_valid ? i_bg_req : pending_q;
            end
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        load_set      = 1'b0;
        o_wr_valid    = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_gen_address = '0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StPrime;
                    wr_addr_d = '0;
                    load_set  = 1'b1;
                end
            end
            StPrime: begin
                // Address 0 is presented here so its colour is ready in the first stream cycle
                o_busy  = 1'b1;
                state_d = i_abort ? StIdle : StStream;
            end
            StStream: begin
                o_busy     = 1'b1;
                o_wr_valid = 1'b1;
                // Look one address ahead only when the current write is taken
                o_gen_address = fire ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
                if (i_abort) begin
                    state_d = StIdle;
                end else if (fire) begin
                    if (wr_addr_q == LAST) begin
                        state_d = StDone;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_bg_set      = bg_set_q;
    assign o_wr_address  = wr_addr_q;
    assign o_wr_data     = i_gen_data;
    assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_background_fill_controller.sv
// Self-checking bench for background_fill_controller.
// A full-size instance runs the directed frame scenarios.
// A small instance covers frame-counter wraparound.
module tb_background_fill_controller;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 6;
    localparam int FCNT_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        bg_req = 2'b00;
    logic              bg_req_valid = 1'b0;
    logic [1:0]        bg_set;
    logic [ADDR_W-1:0] gen_address;
    logic [DATA_W-1:0] gen_data = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic [FCNT_W-1:0] frame_count;

    logic              s_start = 1'b0;
    logic              s_ready = 1'b1;
    logic [1:0]        s_bg_set;
    logic [ADDR_W-1:0] s_gen_address;
    logic [DATA_W-1:0] s_gen_data = '0;
    logic              s_wr_valid;
    logic [ADDR_W-1:0] s_wr_address;
    logic [DATA_W-1:0] s_wr_data;
    logic              s_busy;
    logic              s_done;
    logic [FCNT_W-1:0] s_fc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] cap0, cap1, cap600;

    always #5 clk = ~clk;

    background_fill_controller dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_abort        (abort),
        .i_bg_req       (bg_req),
        .i_bg_req_valid (bg_req_valid),
        .o_bg_set       (bg_set),
        .o_gen_address  (gen_address),
        .i_gen_data     (gen_data),
        .o_wr_valid     (wr_valid),
        .i_wr_ready     (wr_ready),
        .o_wr_address   (wr_address),
        .o_wr_data      (wr_data),
        .o_busy         (busy),
        .o_done         (done),
        .o_frame_count  (frame_count)
    );

    background_fill_controller #(
        .H_TILES (4),
        .V_TILES (2)
    ) dut_small (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (s_start),
        .i_abort        (1'b0),
        .i_bg_req       (2'b00),
        .i_bg_req_valid (1'b0),
        .o_bg_set       (s_bg_set),
        .o_gen_address  (s_gen_address),
        .i_gen_data     (s_gen_data),
        .o_wr_valid     (s_wr_valid),
        .i_wr_ready     (s_ready),
        .o_wr_address   (s_wr_address),
        .o_wr_data      (s_wr_data),
        .o_busy         (s_busy),
        .o_done         (s_done),
        .o_frame_count  (s_fc)
    );

    // Reference colour per (set, address)
    function automatic logic [DATA_W-1:0] gen_model(input logic [1:0] s, input logic [ADDR_W-1:0] a);
        logic [5:0] lo;
        lo = a[5:0];
        case (s)
            2'b00:   return (a == 0) ? 6'd8 : (a == 1) ? 6'd10 : lo + 6'd52;
            2'b01:   return 6'd12;
            default: return lo ^ {s, 4'b0101};
        endcase
    endfunction

    // Registered generators with one-cycle latency
    always @(posedge clk) begin
        gen_data   <= gen_model(bg_set, gen_address);
        s_gen_data <= s_gen_address[5:0] ^ {4'b0000, s_bg_set};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one frame from a start pulse; tallies writes, protocol errors and the done cycle
    task automatic run_frame(input int stall_pct, input int abort_at, input bit req_v,
                             input logic [1:0] req, input bit mid_req, input bit noise,
                             input logic [1:0] exp_set,
                             output int n_wr, output int n_err, output int done_cyc);
        int  cyc;
        int  exp_addr;
        int  idle_cyc;
        bit  aborted;
        bit  fin;
        n_wr = 0; n_err = 0; done_cyc = -1;
        exp_addr = 0; idle_cyc = 0; aborted = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; bg_req_valid = req_v; bg_req = req; wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; bg_req_valid = 1'b0;
        cyc = 1;
        while (!fin) begin
            wr_ready     = (stall_pct > 0 && $urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
            start        = noise && (cyc == 100);
            abort        = 1'b0;
            bg_req_valid = mid_req && (cyc == 3000);
            bg_req       = 2'b01;
            #1;
            if (cyc == 1) begin
                if (wr_valid || !busy || done || gen_address != 0) n_err++;
            end else if (aborted) begin
                if (wr_valid || busy || done) n_err++;
                idle_cyc++;
                if (idle_cyc == 5) fin = 1;
            end else if (done) begin
                done_cyc = cyc;
                if (busy || wr_valid) n_err++;
                if (noise) start = 1'b1;
                fin = 1;
            end else if (!wr_valid || !busy) begin
                n_err++;
            end else begin
                if (wr_address != ADDR_W'(exp_addr) || bg_set != exp_set ||
                    wr_data != gen_model(exp_set, ADDR_W'(exp_addr))) n_err++;
                if (gen_address != (wr_ready ? ADDR_W'(exp_addr + 1) : ADDR_W'(exp_addr))) n_err++;
                if (exp_set == 2'b00 && exp_addr == 0)   cap0   = wr_data;
                if (exp_set == 2'b00 && exp_addr == 1)   cap1   = wr_data;
                if (exp_set == 2'b00 && exp_addr == 600) cap600 = wr_data;
                if (wr_ready) begin
                    n_wr++;
                    if (exp_addr == abort_at) begin
                        abort   = 1'b1;
                        aborted = 1;
                    end
                    exp_addr++;
                end
            end
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                n_err++;
                fin = 1;
            end
        end
        start = 1'b0; abort = 1'b0; bg_req_valid = 1'b0; wr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (busy || wr_valid || done) n_err++;
            @(negedge clk);
        end
    endtask

    int nw, ne, dc;
    int s_fires, s_dones, s_err, s_k;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(wr_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fcount", 32'(frame_count), 0);
        check("rst_bg_set", 32'(bg_set), 0);
        check("rst_wr_addr", 32'(wr_address), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame A: set 00 requested with start, no backpressure
        run_frame(0, -1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, nw, ne, dc);
        check("A_writes", 32'(nw), 8160);
        check("A_errs", 32'(ne), 0);
        check("A_done_cycle", 32'(dc), 8162);
        check("A_fcount", 32'(frame_count), 1);
        check("A_data_addr0", 32'(cap0), 8);
        check("A_data_addr1", 32'(cap1), 10);
        check("A_data_addr600", 32'(cap600), 12);

        // Frame B: ~50% backpressure, same sequence and data
        run_frame(50, -1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, nw, ne, dc);
        check("B_writes", 32'(nw), 8160);
        check("B_errs", 32'(ne), 0);
        check("B_fcount", 32'(frame_count), 2);

        // Frame C: set 01 requested mid-frame must not disturb this frame
        run_frame(0, -1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, nw, ne, dc);
        check("C_errs", 32'(ne), 0);
        check("C_fcount", 32'(frame_count), 3);

        // Frame D: pending set 01 takes effect
        run_frame(0, -1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, nw, ne, dc);
        check("D_writes", 32'(nw), 8160);
        check("D_errs", 32'(ne), 0);
        check("D_bg_set", 32'(bg_set), 1);

        // Frame E: abort on the write to address 4000, set 10 given with start
        run_frame(0, 4000, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, nw, ne, dc);
        check("E_writes", 32'(nw), 4001);
        check("E_errs", 32'(ne), 0);
        check("E_no_done", 32'(dc), 32'hffff_ffff);
        check("E_fcount", 32'(frame_count), 4);

        // Frame F: restart from 0 with stray starts in STREAM and DONE
        run_frame(0, -1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, nw, ne, dc);
        check("F_writes", 32'(nw), 8160);
        check("F_errs", 32'(ne), 0);
        check("F_done_cycle", 32'(dc), 8162);
        check("F_fcount", 32'(frame_count), 5);

        // Asynchronous reset in the middle of STREAM
        @(negedge clk);
        start = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_rst_valid", 32'(wr_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(wr_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_fcount", 32'(frame_count), 0);
        check("arst_bg_set", 32'(bg_set), 0);
        check("arst_wr_addr", 32'(wr_address), 0);
        check("arst_gen_addr", 32'(gen_address), 0);
        @(negedge clk);
        rst = 1'b0;

        // 256 back-to-back frames on the small instance wrap the counter
        s_fires = 0; s_dones = 0; s_err = 0;
        for (int f = 0; f < 256; f++) begin
            @(negedge clk);
            if (f == 255) check("wrap_fcount_255", 32'(s_fc), 255);
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            s_k = 0;
            for (int t = 0; t < 40 && !s_done; t++) begin
                if (s_wr_valid && s_ready) begin
                    if (s_wr_address != ADDR_W'(s_k) || s_wr_data != DATA_W'(s_k) || !s_busy)
                        s_err++;
                    s_k++;
                    s_fires++;
                end
                @(negedge clk);
            end
            if (s_done) s_dones++;
        end
        @(negedge clk);
        check("wrap_fcount_0", 32'(s_fc), 0);
        check("wrap_dones", 32'(s_dones), 256);
        check("wrap_writes", 32'(s_fires), 2048);
        check("wrap_errs", 32'(s_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
